csi_packet_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter. It shares the single CSI-2 byte stream feeding the D-PHY TX FIFO between N_SRC protocol-layer packet sources, e.g. one per virtual channel.
- A grant is held from the first byte to the last byte of a packet, so short and long packets are never interleaved.
- Enforces a maximum packet length and reports per-packet completion and length to the burst controller.

---
 rtl/csi_packet_arbiter_pkg.sv | 22 ++
 rtl/csi_packet_arbiter_rr_select.sv | 33 +++
 rtl/csi_packet_arbiter.sv | 141 ++++++++++++++
 tb/tb_csi_packet_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_packet_arbiter_pkg.sv
// Shared CSI-2 definitions for the packet arbiter: default packet limit,
// arbiter state encoding and the source-id type.
package csi_packet_arbiter_pkg;

  localparam int CSI_MAX_PKT_BYTES = 4096;
  localparam int CSI_MAX_SRC       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Wide enough for the largest supported source count.
  typedef logic [2:0] src_id_t;

  function automatic src_id_t next_src(input src_id_t id, input int n_src);
    if (int'(id) >= n_src - 1) return '0;
    return id + 3'd1;
  endfunction

endpackage

// File: rtl/csi_packet_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// searching cyclically.
module csi_rr_select #(
  parameter int N_SRC = 2,
  parameter int SID_W = 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SID_W-1:0] rr_ptr,
  output logic [SID_W-1:0] grant,
  output logic             found
);

  int               sum;
  logic [SID_W-1:0] idx;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N_SRC) sum = sum - N_SRC;
      idx = SID_W'(sum);
      if (req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csi_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one CSI-2 byte stream between
// N_SRC packet sources, with maximum-length truncation and completion report.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no grant; pick next requester when enabled (one bubble)
//   ST_XFER  | granted source streams bytes to the FIFO until out_last
//   ST_DRAIN | packet was truncated; swallow the source's tail to src_last
module csi_packet_arbiter
  import csi_packet_arbiter_pkg::*;
#(
  parameter int N_SRC         = 2,
  parameter int MAX_PKT_BYTES = CSI_MAX_PKT_BYTES,
  parameter int CNT_W         = $clog2(MAX_PKT_BYTES + 1),
  localparam int SID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [SID_W-1:0]   out_src_id,
  output logic               pkt_done,
  output logic [CNT_W-1:0]   pkt_len,
  output logic               oversize_err
);

  arb_state_t       state_q, state_d;
  logic [SID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SID_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] pkt_len_q, pkt_len_d;
  logic             pkt_done_q, pkt_done_d;
  logic             oversize_err_q, oversize_err_d;

  logic [SID_W-1:0] sel_idx;
  logic             sel_found;
  logic             g_valid, g_last, trunc, hs;
  logic [7:0]       g_data;

  csi_rr_select #(
    .N_SRC (N_SRC),
    .SID_W (SID_W)
  ) u_rr_select (
    .req    (src_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (sel_idx),
    .found  (sel_found)
  );

  assign g_valid = src_valid[grant_q];
  assign g_last  = src_last[grant_q];
  assign g_data  = src_data[{grant_q, 3'b000} +: 8];
  assign trunc   = (byte_cnt_q == CNT_W'(MAX_PKT_BYTES - 1)) & ~g_last;

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    src_ready = '0;
    case (state_q)
      ST_XFER: begin
        out_valid          = g_valid;
        out_data           = g_data;
        out_last           = g_last | trunc;
        src_ready[grant_q] = out_ready;
      end
      ST_DRAIN: src_ready[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign hs = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    byte_cnt_d     = byte_cnt_q;
    pkt_len_d      = pkt_len_q;
    pkt_done_d     = 1'b0;
    oversize_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && sel_found) begin
          grant_d    = sel_idx;
          byte_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (out_last) begin
            pkt_len_d      = byte_cnt_q + 1'b1;
            pkt_done_d     = 1'b1;
            oversize_err_d = trunc;
            rr_ptr_d       = SID_W'(next_src(src_id_t'(grant_q), N_SRC));
            state_d        = trunc ? ST_DRAIN : ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (g_valid && g_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      byte_cnt_q     <= '0;
      pkt_len_q      <= '0;
      pkt_done_q     <= 1'b0;
      oversize_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      byte_cnt_q     <= byte_cnt_d;
      pkt_len_q      <= pkt_len_d;
      pkt_done_q     <= pkt_done_d;
      oversize_err_q <= oversize_err_d;
    end
  end

  assign out_src_id   = grant_q;
  assign pkt_len      = pkt_len_q;
  assign pkt_done     = pkt_done_q;
  assign oversize_err = oversize_err_q;

endmodule

// File: tb/tb_csi_packet_arbiter.sv
// Directed bench for csi_packet_arbiter: two sources, 8-byte packet limit.
module tb_csi_packet_arbiter;
  import csi_packet_arbiter_pkg::*;

  localparam int N    = 2;
  localparam int MAXB = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable;
  logic [N-1:0]   src_valid, src_last, src_ready;
  logic [8*N-1:0] src_data;
  logic           out_valid, out_last, out_ready;
  logic [7:0]     out_data;
  logic [0:0]     out_src_id;
  logic           pkt_done;
  logic [3:0]     pkt_len;
  logic           oversize_err;

  csi_packet_arbiter #(.N_SRC(N), .MAX_PKT_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .out_src_id(out_src_id),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .oversize_err(oversize_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // source model
  logic [8:0] smem [N][128];
  int         rd [N];
  int         wr [N];
  logic       rdy_v = 1'b1;
  logic       en_v = 1'b1;
  int         cyc = 0;

  // observation logs
  logic [7:0] log_data [256];
  int         log_src  [256];
  logic       log_last [256];
  int         log_cyc  [256];
  int         n_out = 0;
  int         done_len [64];
  int         done_cyc [64];
  int         n_done = 0;
  int         err_cyc = 0;
  int         n_err = 0;
  logic       obs_valid;
  logic [7:0] obs_data;

  task automatic push_byte(input int s, input logic [7:0] d, input logic last);
    smem[s][wr[s]] = {last, d};
    wr[s]++;
  endtask

  task automatic push_pkt(input int s, input int len, input int base);
    for (int k = 0; k < len; k++) push_byte(s, 8'(base + k), k == len - 1);
  endtask

  // One clock: drive at negedge, sample the pre-edge view 1ns later.
  task automatic step();
    @(negedge clk);
    out_ready = rdy_v;
    enable    = en_v;
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr[i]) begin
        src_valid[i]       = 1'b1;
        src_data[8*i +: 8] = smem[i][rd[i]][7:0];
        src_last[i]        = smem[i][rd[i]][8];
      end else begin
        src_valid[i]       = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        src_last[i]        = 1'b0;
      end
    end
    #1;
    cyc++;
    obs_valid = out_valid;
    obs_data  = out_data;
    if (out_valid && out_ready && n_out < 256) begin
      log_data[n_out] = out_data;
      log_src[n_out]  = int'(out_src_id);
      log_last[n_out] = out_last;
      log_cyc[n_out]  = cyc;
      n_out++;
    end
    if (pkt_done && n_done < 64) begin
      done_len[n_done] = int'(pkt_len);
      done_cyc[n_done] = cyc;
      n_done++;
    end
    if (oversize_err) begin
      err_cyc = cyc;
      n_err++;
    end
    for (int i = 0; i < N; i++)
      if (src_valid[i] && src_ready[i]) rd[i]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    src_valid = '0; src_last = '0; src_data = '0;
    out_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
    #12;
    checks++;
    if ({src_ready, out_valid, out_last, pkt_done, oversize_err, pkt_len, out_src_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b l=%b done=%b err=%b len=%0d id=%0d want all 0",
               src_ready, out_valid, out_last, pkt_done, oversize_err, pkt_len, out_src_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (dut.state_q !== ST_IDLE || dut.rr_ptr_q !== 1'b0 || dut.byte_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got st=%0d rr=%0d cnt=%0d want 0 0 0",
               dut.state_q, dut.rr_ptr_q, dut.byte_cnt_q);
    end
    checks++;
    if (obs_valid !== 1'b0 || pkt_len !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle_out got v=%b len=%0d want 0 0", obs_valid, pkt_len);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    int n0, d0, c0;
    exp_b = '{8'h00, 8'h01, 8'h00, 8'hC4};
    n0 = n_out; d0 = n_done; c0 = cyc + 1;
    for (int k = 0; k < 4; k++) push_byte(0, exp_b[k], k == 3);
    for (int k = 0; k < 20 && n_done == d0; k++) step();
    checks++;
    if (n_done == d0) begin errors++; $display("FAIL single_timeout got no pkt_done want 1"); end
    checks++;
    if (n_out - n0 != 4) begin errors++; $display("FAIL single_count got %0d want 4", n_out - n0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_data[n0+k] !== exp_b[k] || log_last[n0+k] !== (k == 3) || log_src[n0+k] != 0) begin
        errors++;
        $display("FAIL single_byte%0d got d=%h l=%b s=%0d want d=%h l=%b s=0",
                 k, log_data[n0+k], log_last[n0+k], log_src[n0+k], exp_b[k], k == 3);
      end
    end
    checks++;
    if (log_cyc[n0] != c0 + 1 || log_cyc[n0+3] != c0 + 4 || done_cyc[d0] != c0 + 5) begin
      errors++;
      $display("FAIL single_timing got first=%0d last=%0d done=%0d want %0d %0d %0d",
               log_cyc[n0] - c0, log_cyc[n0+3] - c0, done_cyc[d0] - c0, 1, 4, 5);
    end
    checks++;
    if (done_len[d0] != 4 || dut.rr_ptr_q !== 1'b1) begin
      errors++;
      $display("FAIL single_len_rr got len=%0d rr=%0d want 4 1", done_len[d0], dut.rr_ptr_q);
    end
    step();
    checks++;
    if (pkt_done !== 1'b0 || pkt_len !== 4'd4) begin
      errors++;
      $display("FAIL single_pulse got done=%b len=%0d want 0 4", pkt_done, pkt_len);
    end
  endtask

  task automatic test_back_to_back();
    int n0, d0, s, j, i;
    do_reset();
    n0 = n_out; d0 = n_done;
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 6, p * 16);
      push_pkt(1, 6, 64 + p * 16);
    end
    for (int k = 0; k < 100 && n_done < d0 + 6; k++) step();
    checks++;
    if (n_done != d0 + 6 || n_out - n0 != 36) begin
      errors++;
      $display("FAIL b2b_count got pkts=%0d bytes=%0d want 6 36", n_done - d0, n_out - n0);
    end
    for (int p = 0; p < 6; p++) begin
      s = p % 2; j = p / 2;
      for (int k = 0; k < 6; k++) begin
        i = n0 + p * 6 + k;
        checks++;
        if (log_src[i] != s || log_data[i] !== 8'(s * 64 + j * 16 + k) || log_last[i] !== (k == 5)) begin
          errors++;
          $display("FAIL b2b_p%0d_b%0d got s=%0d d=%h l=%b want s=%0d d=%h l=%b",
                   p, k, log_src[i], log_data[i], log_last[i], s, 8'(s * 64 + j * 16 + k), k == 5);
        end
      end
      checks++;
      if (done_len[d0+p] != 6) begin
        errors++;
        $display("FAIL b2b_len%0d got %0d want 6", p, done_len[d0+p]);
      end
      if (p > 0) begin
        checks++;
        if (log_cyc[n0+p*6] - log_cyc[n0+p*6-1] != 2) begin
          errors++;
          $display("FAIL b2b_bubble%0d got gap=%0d want 2", p, log_cyc[n0+p*6] - log_cyc[n0+p*6-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int n0, d0;
    n0 = n_out; d0 = n_done;
    push_pkt(0, 6, 8'hA0);
    for (int t = 0; t < 30 && n_done == d0; t++) begin
      rdy_v = (t == 2 || t == 3) ? 1'b0 : 1'b1;
      step();
      if (t == 2 || t == 3) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 8'hA1 || dut.byte_cnt_q !== 4'd1) begin
          errors++;
          $display("FAIL stall_hold_t%0d got v=%b d=%h cnt=%0d want 1 a1 1",
                   t, obs_valid, obs_data, dut.byte_cnt_q);
        end
      end
      if (t == 4) begin
        checks++;
        if (n_out - n0 != 2) begin
          errors++;
          $display("FAIL stall_resume got bytes=%0d want 2", n_out - n0);
        end
      end
    end
    rdy_v = 1'b1;
    checks++;
    if (n_out - n0 != 6 || n_done != d0 + 1 || done_len[d0] != 6) begin
      errors++;
      $display("FAIL stall_result got bytes=%0d pkts=%0d len=%0d want 6 1 6",
               n_out - n0, n_done - d0, done_len[d0]);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (log_data[n0+k] !== 8'(8'hA0 + k)) begin
        errors++;
        $display("FAIL stall_byte%0d got %h want %h", k, log_data[n0+k], 8'(8'hA0 + k));
      end
    end
  endtask

  task automatic test_oversize();
    int n0, d0, e0;
    n0 = n_out; d0 = n_done; e0 = n_err;
    push_pkt(1, 12, 8'hB0);
    push_pkt(0, 3, 8'hC0);
    for (int k = 0; k < 60 && n_done < d0 + 2; k++) step();
    repeat (2) step();
    checks++;
    if (n_out - n0 != 11 || n_done != d0 + 2) begin
      errors++;
      $display("FAIL ovs_count got bytes=%0d pkts=%0d want 11 2", n_out - n0, n_done - d0);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (log_src[n0+k] != 1 || log_data[n0+k] !== 8'(8'hB0 + k) || log_last[n0+k] !== (k == 7)) begin
        errors++;
        $display("FAIL ovs_byte%0d got s=%0d d=%h l=%b want s=1 d=%h l=%b",
                 k, log_src[n0+k], log_data[n0+k], log_last[n0+k], 8'(8'hB0 + k), k == 7);
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (log_src[n0+8+k] != 0 || log_data[n0+8+k] !== 8'(8'hC0 + k) || log_last[n0+8+k] !== (k == 2)) begin
        errors++;
        $display("FAIL ovs_next%0d got s=%0d d=%h l=%b want s=0 d=%h l=%b",
                 k, log_src[n0+8+k], log_data[n0+8+k], log_last[n0+8+k], 8'(8'hC0 + k), k == 2);
      end
    end
    checks++;
    if (n_err - e0 != 1 || err_cyc != done_cyc[d0]) begin
      errors++;
      $display("FAIL ovs_err got pulses=%0d at=%0d want 1 at %0d", n_err - e0, err_cyc, done_cyc[d0]);
    end
    checks++;
    if (done_len[d0] != 8 || done_len[d0+1] != 3) begin
      errors++;
      $display("FAIL ovs_len got %0d %0d want 8 3", done_len[d0], done_len[d0+1]);
    end
    checks++;
    if (rd[1] != wr[1] || log_cyc[n0+8] - log_cyc[n0+7] != 6) begin
      errors++;
      $display("FAIL ovs_drain got left=%0d gap=%0d want 0 6", wr[1] - rd[1], log_cyc[n0+8] - log_cyc[n0+7]);
    end
  endtask

  task automatic test_enable();
    int n0, d0, ce;
    n0 = n_out; d0 = n_done;
    en_v = 1'b1;
    push_pkt(0, 4, 8'hD0);
    step();
    push_pkt(1, 4, 8'hE0);
    step();
    en_v = 1'b0;
    repeat (12) step();
    checks++;
    if (n_out - n0 != 4 || n_done != d0 + 1 || log_src[n0+3] != 0 || log_data[n0+3] !== 8'hD3) begin
      errors++;
      $display("FAIL en_finish got bytes=%0d pkts=%0d s=%0d d=%h want 4 1 0 d3",
               n_out - n0, n_done - d0, log_src[n0+3], log_data[n0+3]);
    end
    checks++;
    if (obs_valid !== 1'b0 || dut.state_q !== ST_IDLE || wr[1] - rd[1] != 4) begin
      errors++;
      $display("FAIL en_hold got v=%b st=%0d pend=%0d want 0 0 4", obs_valid, dut.state_q, wr[1] - rd[1]);
    end
    en_v = 1'b1;
    ce = cyc + 1;
    for (int k = 0; k < 20 && n_done < d0 + 2; k++) step();
    checks++;
    if (n_done != d0 + 2 || log_src[n0+4] != 1 || log_data[n0+4] !== 8'hE0 || log_cyc[n0+4] != ce + 1) begin
      errors++;
      $display("FAIL en_regrant got pkts=%0d s=%0d d=%h dt=%0d want 2 1 e0 1",
               n_done - d0, log_src[n0+4], log_data[n0+4], log_cyc[n0+4] - ce);
    end
    checks++;
    if (out_src_id !== 1'b1 || done_len[d0+1] != 4) begin
      errors++;
      $display("FAIL en_id got id=%0d len=%0d want 1 4", out_src_id, done_len[d0+1]);
    end
  endtask

  task automatic test_reset_mid();
    int n0, d0;
    n0 = n_out; d0 = n_done;
    push_pkt(0, 6, 8'h50);
    for (int k = 0; k < 20 && n_out - n0 < 3; k++) step();
    checks++;
    if (n_out - n0 != 3) begin errors++; $display("FAIL rstmid_setup got bytes=%0d want 3", n_out - n0); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({src_ready, out_valid, out_last, pkt_done, oversize_err, pkt_len, out_src_id, out_data} !== '0) begin
      errors++;
      $display("FAIL rstmid_async got rdy=%b v=%b l=%b done=%b err=%b len=%0d id=%0d d=%h want all 0",
               src_ready, out_valid, out_last, pkt_done, oversize_err, pkt_len, out_src_id, out_data);
    end
    for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (n_done != d0 || dut.state_q !== ST_IDLE || dut.rr_ptr_q !== 1'b0 || pkt_len !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_after got pkts=%0d st=%0d rr=%0d len=%0d want 0 0 0 0",
               n_done - d0, dut.state_q, dut.rr_ptr_q, pkt_len);
    end
    n0 = n_out;
    push_pkt(1, 2, 8'h70);
    for (int k = 0; k < 20 && n_done == d0; k++) step();
    checks++;
    if (n_done != d0 + 1 || done_len[d0] != 2 || log_src[n0] != 1 || log_data[n0+1] !== 8'h71) begin
      errors++;
      $display("FAIL rstmid_recover got pkts=%0d len=%0d s=%0d d=%h want 1 2 1 71",
               n_done - d0, done_len[d0], log_src[n0], log_data[n0+1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_oversize();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish by 200000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
